// File: rtl/dffre_pkg.sv
// Shared definitions for the dffre elastic pipeline: occupancy width helper and reset data value.
package dffre_pkg;

    localparam logic RST_BIT = 1'b0;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffre_pipe_stage.sv
// One elastic stage: WIDTH-bit data register, valid bit and its local ready term.
module dffre_pipe_stage
    import dffre_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    // An empty stage always accepts, which is what collapses bubbles.
    assign rdy = !vld | down_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= 1'b0;
            data <= {WIDTH{RST_BIT}};
        end else if (flush) begin
            vld <= 1'b0;
        end else if (en && rdy) begin
            vld <= up_valid;
            // Data only moves with a valid word so a bubble never clobbers held data.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dffre_pipe.sv
// Elastic valid/ready register pipeline of DEPTH stages with global enable and flush.
// Optional occupancy counter port enabled by defining DFFRE_PIPE_OCCUPANCY_EN.
module dffre_pipe
    import dffre_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
`ifdef DFFRE_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_w(DEPTH)-1:0]    occupancy
`endif
);

    logic             vld    [DEPTH];
    logic [WIDTH-1:0] data_s [DEPTH];
    logic             rdy    [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;

        if (i == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_mid
            assign up_valid = vld[i-1];
            assign up_data  = data_s[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign down_ready = out_ready;
        end else begin : g_chain
            assign down_ready = rdy[i+1];
        end

        dffre_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .vld        (vld[i]),
            .data       (data_s[i]),
            .rdy        (rdy[i])
        );
    end

    // Valid/ready: a word moves across a boundary only on a cycle where both are high
    // at the rising edge; ready never depends combinationally on in_valid.
    assign in_ready  = en & rdy[0] & !flush & !reset;
    assign out_valid = en & vld[DEPTH-1];
    assign out_data  = data_s[DEPTH-1];

`ifdef DFFRE_PIPE_OCCUPANCY_EN
    localparam int OCC_W = occ_w(DEPTH);

    logic in_xfer;
    logic out_xfer;
    logic [OCC_W-1:0] occ_q;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end
`else
    // Without the counter the pipe carries no occupancy state.
`endif

endmodule

// File: tb/tb_dffre_pipe.sv
// Bench for dffre_pipe (WIDTH=16, DEPTH=3): position-queue model plus directed literal checks.
module tb_dffre_pipe;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DFFRE_PIPE_OCCUPANCY_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit started  = 1'b0;
    int n_out;

    // Words in flight, oldest first, with the stage position each one occupies.
    logic [WIDTH-1:0] exp_q[$];
    int               pos_q[$];

    always #5 clk = ~clk;

    dffre_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DFFRE_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_occ(input string name, input int exp);
`ifdef DFFRE_PIPE_OCCUPANCY_EN
        check(name, 32'(occupancy), exp);
`else
        if (exp < 0) $display("occupancy expectation below zero in %s", name);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_in_ready();
        return en && !flush && !reset && (exp_q.size() < DEPTH || out_ready);
    endfunction

    function automatic bit m_out_valid();
        return en && (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
    endfunction

    // Model: a word advances when any slot ahead of it is free or the sink takes a word.
    always @(posedge clk) begin
        bit in_x;
        bit drop;
        if (reset || flush) begin
            exp_q.delete();
            pos_q.delete();
        end else if (en) begin
            in_x = in_valid && m_in_ready();
            drop = 1'b0;
            for (int k = 0; k < pos_q.size(); k++) begin
                if ((k < DEPTH - 1 - pos_q[k]) || out_ready) begin
                    if (pos_q[k] == DEPTH - 1) drop = 1'b1;
                    else pos_q[k] = pos_q[k] + 1;
                end
            end
            if (drop) begin
                void'(exp_q.pop_front());
                void'(pos_q.pop_front());
            end
            if (in_x) begin
                exp_q.push_back(in_data);
                pos_q.push_back(0);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready", in_ready, m_in_ready());
            check("out_valid", out_valid, m_out_valid());
            if (m_out_valid()) check("out_data", out_data, exp_q[0]);
            check_occ("occupancy", exp_q.size());
        end
    end

    initial begin
        reset = 1; en = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 1;
        step();
        step();
        started = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check_occ("rst_occ", 0);
        step();
        reset = 0;

        // Back-to-back stream: first word visible three cycles after its accept.
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_data = WIDTH'(i);
            @(negedge clk);
            check("t1_in_ready", in_ready, 1);
            if (i == 3) check("t1_not_yet", out_valid, 0);
            if (i == 4) begin
                check("t1_lat_valid", out_valid, 1);
                check("t1_lat_data", out_data, 16'h0001);
            end
            step();
        end
        in_valid = 0;
        repeat (6) step();

        // Stalled sink: three words fill the pipe, the fourth is refused.
        out_ready = 0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1; in_data = WIDTH'(16'h10 + j);
            @(negedge clk);
            check("t2_in_ready", in_ready, (j < 3) ? 1 : 0);
            step();
        end
        @(negedge clk);
        check("t2_full_ready", in_ready, 0);
        check("t2_head", out_data, 16'h0010);
        check_occ("t2_occ", 3);
        step();
        @(negedge clk);
        check("t2_head_stable", out_data, 16'h0010);

        // Full pipe streaming at one word per cycle.
        out_ready = 1;
        n_out = 0;
        for (int k = 0; k < 10; k++) begin
            in_data = WIDTH'(16'h13 + k);
            @(negedge clk);
            check("t3_in_ready", in_ready, 1);
            check_occ("t3_occ", 3);
            if (out_valid && out_ready) n_out++;
            step();
        end
        check("t3_out_count", n_out, 10);

        // Freeze mid-stream, then resume.
        in_data = 16'h1D;
        en = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_in_ready", in_ready, 0);
            check("t4_out_valid", out_valid, 0);
            check("t4_held", out_data, 16'h001A);
            step();
        end
        en = 1;
        for (int k = 0; k < 4; k++) begin
            in_data = WIDTH'(16'h1D + k);
            step();
        end
        in_valid = 0;
        repeat (6) step();

        // Flush with two words in flight and one offered.
        out_ready = 0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1; in_data = WIDTH'(16'h21 + j);
            step();
        end
        in_data = 16'h00AA; flush = 1;
        @(negedge clk);
        check("t5_flush_ready", in_ready, 0);
        step();
        flush = 0; in_valid = 0;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check_occ("t5_occ", 0);
        out_ready = 1;
        repeat (5) step();

        // Reset with a full pipe, then accept resumes once reset is low.
        out_ready = 0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1; in_data = WIDTH'(16'h31 + j);
            step();
        end
        in_valid = 0; reset = 1;
        step();
        @(negedge clk);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_in_ready", in_ready, 0);
        check_occ("t6_occ", 0);
        reset = 0; in_valid = 1; in_data = 16'h0055; out_ready = 1;
        #1;
        check("t6_resume_ready", in_ready, 1);
        step();
        in_valid = 0;
        repeat (5) step();
        @(negedge clk);
        check("t6_drained", out_valid, 0);
        check_occ("t6_drained_occ", 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
